ck_seq_checker: RTL

- Downstream consumer of the stride counter's bit-reversed 8-bit output.
- Un-reverses each sample and predicts the next value as previous + STEP (mod 2^WIDTH).
- Acquires lock after a run of correct samples and flywheels through isolated corruptions.
- Counts mismatches for link/self-test status and reports lock state to the control logic.

---
 rtl/ck_seq_checker.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/ck_seq_checker.sv
`default_nettype none
// ============================================================================
// Module   : ck_seq_checker
// Purpose  : Un-reverses a bit-reversed stride-counter stream, locks onto it,
//            flywheels through corruptions and counts mismatches.
// Option   : CK_SEQ_ERRCAP_EN adds first-error capture (cap_vld/exp/got).
// Revision : 1.0 - initial release
// ============================================================================
module ck_seq_checker #(
    parameter int WIDTH      = 8,
    parameter int STEP       = 7,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             init_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             clr,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       state
`ifdef CK_SEQ_ERRCAP_EN
    ,
    output logic             cap_vld,
    output logic [WIDTH-1:0] cap_exp,
    output logic [WIDTH-1:0] cap_got
`endif
);

    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(UNLOCK_CNT + 1);
    localparam logic [RUN_W-1:0]  LOCK_TGT   = RUN_W'(LOCK_CNT);
    localparam logic [MISS_W-1:0] UNLOCK_TGT = MISS_W'(UNLOCK_CNT);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ACQ    = 2'd1,
        LOCK   = 2'd2,
        SLIP   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   prev_q, prev_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic               err_q, err_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

    logic [WIDTH-1:0]   d_w;
    logic [WIDTH-1:0]   exp_w;
    logic               match_w;

    always_comb begin
        d_w = '0;
        for (int i = 0; i < WIDTH; i++) begin
            d_w[i] = din[WIDTH-1-i];
        end
    end

    assign exp_w   = prev_q + WIDTH'(STEP);
    assign match_w = (d_w == exp_w);

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        run_d   = run_q;
        miss_d  = miss_q;
        err_d   = 1'b0;
        if (en) begin
            case (state_q)
                SEARCH: begin
                    prev_d  = d_w;
                    run_d   = '0;
                    state_d = ACQ;
                end
                ACQ: begin
                    prev_d = d_w;
                    if (match_w) begin
                        run_d = run_q + RUN_W'(1);
                        if (run_q + RUN_W'(1) == LOCK_TGT) begin
                            state_d = LOCK;
                            run_d   = '0;
                            miss_d  = '0;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                LOCK: begin
                    // Flywheel: advance on the prediction so one bad sample costs one error.
                    prev_d = exp_w;
                    if (!match_w) begin
                        err_d   = 1'b1;
                        miss_d  = MISS_W'(1);
                        state_d = (UNLOCK_CNT == 1) ? SEARCH : SLIP;
                    end
                end
                default: begin
                    prev_d = exp_w;
                    if (match_w) begin
                        miss_d  = '0;
                        state_d = LOCK;
                    end else begin
                        err_d  = 1'b1;
                        miss_d = miss_q + MISS_W'(1);
                        if (miss_q + MISS_W'(1) == UNLOCK_TGT) begin
                            state_d = ACQ;
                            prev_d  = d_w;
                            run_d   = '0;
                            miss_d  = '0;
                        end
                    end
                end
            endcase
        end
    end

    // clr wins over a same-cycle increment; the count sticks at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr) begin
            err_cnt_d = '0;
        end else if (err_d && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q   <= SEARCH;
            prev_q    <= '0;
            run_q     <= '0;
            miss_q    <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            run_q     <= run_d;
            miss_q    <= miss_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign state   = state_q;
    assign locked  = state_q[1];
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

`ifdef CK_SEQ_ERRCAP_EN
    logic             cap_vld_q, cap_vld_d;
    logic [WIDTH-1:0] cap_exp_q, cap_exp_d;
    logic [WIDTH-1:0] cap_got_q, cap_got_d;

    always_comb begin
        cap_vld_d = cap_vld_q;
        cap_exp_d = cap_exp_q;
        cap_got_d = cap_got_q;
        if (clr) begin
            cap_vld_d = 1'b0;
            cap_exp_d = '0;
            cap_got_d = '0;
        end else if (err_d && !cap_vld_q) begin
            cap_vld_d = 1'b1;
            cap_exp_d = exp_w;
            cap_got_d = d_w;
        end
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            cap_vld_q <= 1'b0;
            cap_exp_q <= '0;
            cap_got_q <= '0;
        end else begin
            cap_vld_q <= cap_vld_d;
            cap_exp_q <= cap_exp_d;
            cap_got_q <= cap_got_d;
        end
    end

    assign cap_vld = cap_vld_q;
    assign cap_exp = cap_exp_q;
    assign cap_got = cap_got_q;
`endif

endmodule

`default_nettype wire
